// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder and the multicycle control unit
// that drives it over the MFA/MOC handshake.
//   - size and RW encodings as seen on the request lines
//   - responder FSM state type
//   - captured-request struct
//   - alignment helper
package mem_responder_pkg;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_BYTE = 2'b01;
   localparam logic [1:0] SZ_HALF = 2'b10;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } mem_state_e;

   // Request attributes latched on MFA; address/data live beside it because
   // their width depends on the instance.
   typedef struct packed {
      logic       rw;
      logic [1:0] size;
      logic       unsign;
   } mem_req_t;

   // Byte is always aligned, half needs an even address, word (and the
   // reserved 2'b11 encoding, treated as word) needs a multiple of four.
   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a_lo);
      case (sz)
         SZ_BYTE: is_misaligned = 1'b0;
         SZ_HALF: is_misaligned = a_lo[0];
         default: is_misaligned = (a_lo != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational read formatter.
//   raw     : the four bytes starting at the access address, big-endian
//             (byte at addr in raw[31:24])
//   size    : access size encoding
//   unSign  : 1 = zero-extend byte/half, 0 = sign-extend
//   data    : formatted 32-bit read result
module mem_byte_lane
   import mem_responder_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [1:0]  size,
   input  logic        unSign,
   output logic [31:0] data
);

   always_comb begin
      data = raw;
      case (size)
         SZ_BYTE: data = {{24{~unSign & raw[31]}}, raw[31:24]};
         SZ_HALF: data = {{16{~unSign & raw[31]}}, raw[31:16]};
         default: data = raw;
      endcase
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR/MOC handshake.
//   clk, Reset : clock, synchronous active-high reset
//   MFA        : request strobe, held by the initiator until MOC
//   RW         : 1 = read, 0 = write
//   size       : 00 word, 01 byte, 10 half, 11 word
//   unSign     : zero- (1) or sign- (0) extend byte/half reads
//   address    : byte address
//   dataIn     : write data (byte/half from the low bits)
//   dataOut    : registered read data, held until the next completed read
//   MOC        : operation complete, high in DONE
//   misalign   : valid with MOC, request was misaligned (nothing written)
// Storage is a byte-addressed big-endian array that is never cleared.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH  = 9,
   parameter int WAIT_CYCLES = 2
)(
   input  logic                  clk,
   input  logic                  Reset,
   input  logic                  MFA,
   input  logic                  RW,
   input  logic [1:0]            size,
   input  logic                  unSign,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [31:0]           dataIn,
   output logic [31:0]           dataOut,
   output logic                  MOC,
   output logic                  misalign
);

   localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   mem_state_e            state;
   logic [CW-1:0]         cnt;
   mem_req_t              req_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           din_q;

   logic [7:0] mem [2**ADDR_WIDTH];

   logic [ADDR_WIDTH-1:0] a1, a2, a3;
   logic [31:0]           raw, rd_fmt;
   logic                  mis, fire;

   // Offsets wrap naturally at ADDR_WIDTH; only byte/half reads near the top
   // ever touch wrapped bytes, and the formatter discards them.
   assign a1  = addr_q + ADDR_WIDTH'(1);
   assign a2  = addr_q + ADDR_WIDTH'(2);
   assign a3  = addr_q + ADDR_WIDTH'(3);
   assign raw = {mem[addr_q], mem[a1], mem[a2], mem[a3]};
   assign mis = is_misaligned(req_q.size, addr_q[1:0]);

   // Access happens on the edge leaving WAIT. The capture edge plus
   // WAIT_CYCLES+1 counted edges gives MOC after edge N+WAIT_CYCLES+1.
   assign fire = (state == ST_WAIT) && (cnt == '0);

   mem_byte_lane u_lane (
      .raw    (raw),
      .size   (req_q.size),
      .unSign (req_q.unsign),
      .data   (rd_fmt)
   );

   // Array write; Reset on the firing edge aborts the write.
   always_ff @(posedge clk) begin
      if (!Reset && fire && req_q.rw == RW_WRITE && !mis) begin
         case (req_q.size)
            SZ_BYTE: mem[addr_q] <= din_q[7:0];
            SZ_HALF: begin
               mem[addr_q] <= din_q[15:8];
               mem[a1]     <= din_q[7:0];
            end
            default: begin
               mem[addr_q] <= din_q[31:24];
               mem[a1]     <= din_q[23:16];
               mem[a2]     <= din_q[15:8];
               mem[a3]     <= din_q[7:0];
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         MOC      <= 1'b0;
         misalign <= 1'b0;
         dataOut  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (MFA) begin
                  req_q  <= '{rw: RW, size: size, unsign: unSign};
                  addr_q <= address;
                  din_q  <= dataIn;
                  cnt    <= CW'(WAIT_CYCLES);
                  state  <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (fire) begin
                  state    <= ST_DONE;
                  MOC      <= 1'b1;
                  misalign <= mis;
                  if (req_q.rw == RW_READ)
                     dataOut <= mis ? 32'h0 : rd_fmt;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_DONE: begin
               // Leaving DONE consumes the edge; a new request needs MFA
               // sampled high on a later edge.
               if (!MFA) begin
                  MOC      <= 1'b0;
                  misalign <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
   import mem_responder_pkg::*;

   localparam int AW = 9;
   localparam int MEMSZ = 1 << AW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  rst;
   logic [1:0]  mfa, rw, us, moc, mis;
   logic [1:0]  sz [2];
   logic [AW-1:0] addr [2];
   logic [31:0] din [2];
   logic [31:0] dout [2];

   mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) dut0 (
      .clk(clk), .Reset(rst[0]), .MFA(mfa[0]), .RW(rw[0]), .size(sz[0]),
      .unSign(us[0]), .address(addr[0]), .dataIn(din[0]),
      .dataOut(dout[0]), .MOC(moc[0]), .misalign(mis[0]));

   mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut1 (
      .clk(clk), .Reset(rst[1]), .MFA(mfa[1]), .RW(rw[1]), .size(sz[1]),
      .unSign(us[1]), .address(addr[1]), .dataIn(din[1]),
      .dataOut(dout[1]), .MOC(moc[1]), .misalign(mis[1]));

   int checks = 0;
   int errors = 0;
   int wait_of [2] = '{2, 0};

   typedef struct {
      logic [31:0] data;
      logic        mis;
   } exp_t;

   exp_t        expq [2][$];
   int          mdl [2][MEMSZ];   // reference byte memory
   logic [31:0] last_rd [2];
   logic [1:0]  prev_moc = 2'b00;

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s dut%0d actual=%h required=%h t=%0t", name, d, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit m_mis(input logic [1:0] s, input int a);
      if (s == SZ_BYTE) return 1'b0;
      if (s == SZ_HALF) return (a % 2) != 0;
      return (a % 4) != 0;
   endfunction

   function automatic logic [31:0] m_read(input int d, input logic [1:0] s, input bit u, input int a);
      longint v;
      if (s == SZ_BYTE) begin
         v = mdl[d][a];
         if (!u && v >= 128) v = v - 256;
      end else if (s == SZ_HALF) begin
         v = mdl[d][a] * 256 + mdl[d][(a + 1) % MEMSZ];
         if (!u && v >= 32768) v = v - 65536;
      end else begin
         v = ((longint'(mdl[d][a]) * 256 + mdl[d][a+1]) * 256 + mdl[d][a+2]) * 256 + mdl[d][a+3];
      end
      return v[31:0];
   endfunction

   task automatic m_write(input int d, input logic [1:0] s, input int a, input logic [31:0] w);
      longint x;
      x = longint'(w);
      if (s == SZ_BYTE) mdl[d][a] = int'(x % 256);
      else if (s == SZ_HALF) begin
         mdl[d][a]   = int'((x / 256) % 256);
         mdl[d][a+1] = int'(x % 256);
      end else begin
         for (int i = 0; i < 4; i++)
            mdl[d][a+i] = int'((x >> (8 * (3 - i))) % 256);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   task automatic monitor(input int d);
      exp_t e;
      if (moc[d] && !prev_moc[d]) begin
         if (expq[d].size() == 0) begin
            chk("unexpected_moc", d, 32'd1, 32'd0);
         end else begin
            e = expq[d].pop_front();
            chk("dataOut", d, dout[d], e.data);
            chk("misalign", d, {31'd0, mis[d]}, {31'd0, e.mis});
         end
      end
      if (!moc[d]) chk("misalign_idle", d, {31'd0, mis[d]}, 32'd0);
      prev_moc[d] = moc[d];
   endtask

   always @(posedge clk) begin
      #1;
      monitor(0);
      monitor(1);
   end

   // ---------------- driver ----------------
   task automatic do_op(input int d, input bit rd, input logic [1:0] s, input bit u,
                        input int a, input logic [31:0] w, input int hold);
      exp_t e;
      int n;
      bit m;
      m = m_mis(s, a);
      if (rd) begin
         last_rd[d] = m ? 32'h0 : m_read(d, s, u, a);
      end else if (!m) begin
         m_write(d, s, a, w);
      end
      e.data = last_rd[d];
      e.mis  = m;
      expq[d].push_back(e);

      @(negedge clk);
      mfa[d] = 1'b1; rw[d] = rd; sz[d] = s; us[d] = u;
      addr[d] = AW'(a); din[d] = w;
      @(posedge clk);               // capture edge
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!moc[d] && n < 20);
      chk("latency", d, 32'(n), 32'(wait_of[d] + 1));
      // scramble inputs while MOC held; they must not matter
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         rw[d] = ~rw[d]; addr[d] = AW'($urandom); din[d] = $urandom;
         @(posedge clk); #1;
         chk("moc_hold", d, {31'd0, moc[d]}, 32'd1);
      end
      @(negedge clk);
      mfa[d] = 1'b0;
      @(posedge clk); #1;
      chk("moc_drop", d, {31'd0, moc[d]}, 32'd0);
   endtask

   // Reset lands while the write is waiting: nothing completes, array untouched.
   task automatic reset_abort(input int d);
      @(negedge clk);
      mfa[d] = 1'b1; rw[d] = RW_WRITE; sz[d] = SZ_WORD; us[d] = 1'b0;
      addr[d] = AW'(32'h020); din[d] = 32'hCAFEF00D;
      @(posedge clk);
      @(negedge clk);
      rst[d] = 1'b1; mfa[d] = 1'b0;
      @(posedge clk); #1;
      chk("abort_moc", d, {31'd0, moc[d]}, 32'd0);
      chk("abort_dout", d, dout[d], 32'd0);
      @(negedge clk);
      rst[d] = 1'b0;
      last_rd[d] = 32'h0;
      repeat (4) begin
         @(posedge clk); #1;
         chk("abort_quiet", d, {31'd0, moc[d]}, 32'd0);
      end
      do_op(d, 1, SZ_WORD, 0, 32'h020, 0, 0);
   endtask

   // Reset and MFA on the same edge: request is not captured.
   task automatic reset_with_mfa(input int d);
      @(negedge clk);
      rst[d] = 1'b1; mfa[d] = 1'b1; rw[d] = RW_WRITE; sz[d] = SZ_WORD;
      addr[d] = AW'(32'h030); din[d] = 32'hA5A5A5A5;
      @(posedge clk);
      @(negedge clk);
      rst[d] = 1'b0; mfa[d] = 1'b0;
      last_rd[d] = 32'h0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("rstmfa_quiet", d, {31'd0, moc[d]}, 32'd0);
      end
      do_op(d, 1, SZ_WORD, 0, 32'h030, 0, 0);
   endtask

   task automatic run(input int d);
      logic [1:0] s;
      int a;
      // known memory contents for the model
      for (int i = 0; i < MEMSZ; i += 4) do_op(d, 0, SZ_WORD, 0, i, 32'h0, 0);
      do_op(d, 0, SZ_WORD, 0, 32'h010, 32'hDEADBEEF, 0);
      do_op(d, 1, SZ_WORD, 0, 32'h010, 0, 0);
      do_op(d, 1, SZ_BYTE, 0, 32'h011, 0, 0);
      do_op(d, 1, SZ_BYTE, 1, 32'h011, 0, 0);
      do_op(d, 1, SZ_HALF, 0, 32'h012, 0, 1);
      do_op(d, 0, SZ_BYTE, 0, 32'h012, 32'h00000055, 0);
      do_op(d, 1, SZ_WORD, 0, 32'h010, 0, 4);
      do_op(d, 0, SZ_WORD, 0, 32'h013, 32'h12345678, 0);
      do_op(d, 1, SZ_WORD, 0, 32'h010, 0, 0);
      do_op(d, 1, SZ_WORD, 0, 32'h013, 0, 0);
      do_op(d, 1, SZ_HALF, 1, 32'h1FE, 0, 0);
      do_op(d, 1, SZ_BYTE, 0, 32'h1FF, 0, 0);
      reset_abort(d);
      reset_with_mfa(d);
      for (int k = 0; k < 150; k++) begin
         s = 2'($urandom_range(0, 3));
         a = $urandom_range(0, MEMSZ - 1);
         if ($urandom_range(0, 3) != 0) a = a & ~3;   // mostly aligned
         if (s != SZ_BYTE && (a & 3) == 0 && a > MEMSZ - 4) a = MEMSZ - 4;
         do_op(d, $urandom_range(0, 1), s, $urandom_range(0, 1), a, $urandom, $urandom_range(0, 2));
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
   endtask

   initial begin
      rst = 2'b11; mfa = 2'b00; rw = 2'b00; us = 2'b00;
      for (int d = 0; d < 2; d++) begin
         sz[d] = SZ_WORD; addr[d] = '0; din[d] = '0; last_rd[d] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 2'b00;
      repeat (5) begin
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++) begin
            chk("rst_moc", d, {31'd0, moc[d]}, 32'd0);
            chk("rst_dout", d, dout[d], 32'd0);
            chk("rst_mis", d, {31'd0, mis[d]}, 32'd0);
         end
      end
      fork
         run(0);
         run(1);
      join
      repeat (3) @(posedge clk);
      #2;
      for (int d = 0; d < 2; d++)
         chk("pending", d, 32'(expq[d].size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
